// File: rtl/ra_pq_kvsel_n_if.sv
// Handshake bundle for the N-channel key-value selector.
// The slave modport is the selector's view; master is the surrounding environment.
interface ra_pq_kvsel_n_if #(
  parameter int NCH = 4,
  parameter int KW  = 16,
  parameter int VW  = 16,
  parameter int SW  = $clog2(NCH)
);
  logic [NCH-1:0]    in_valid;
  logic [NCH*KW-1:0] in_key;
  logic [NCH*VW-1:0] in_val;
  logic [NCH-1:0]    in_ack;
  logic              out_valid;
  logic [KW-1:0]     out_key;
  logic [VW-1:0]     out_val;
  logic [SW-1:0]     out_src;
  logic              out_ready;

  modport master (
    output in_valid, in_key, in_val, out_ready,
    input  in_ack, out_valid, out_key, out_val, out_src
  );

  modport slave (
    input  in_valid, in_key, in_val, out_ready,
    output in_ack, out_valid, out_key, out_val, out_src
  );
endinterface

// File: rtl/ra_pq_kvsel_n.sv
// N-channel min-key selector with round-robin tie break and a one-deep output register.
// Define RA_PQ_KVSEL_MAX_EN to select the largest key instead (max-queue mode).
module ra_pq_kvsel_n #(
  parameter int NCH   = 4,
  parameter int KW    = 16,
  parameter int VW    = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ra_pq_kvsel_n_if.slave    bus,
  output logic [CNT_W-1:0]  sel_count
);
  localparam int SW = $clog2(NCH);

  logic [KW-1:0]    key_arr [NCH];
  logic [VW-1:0]    val_arr [NCH];

  logic             out_valid_q, out_valid_d;
  logic [KW-1:0]    out_key_q, out_key_d;
  logic [VW-1:0]    out_val_q, out_val_d;
  logic [SW-1:0]    out_src_q, out_src_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] sel_count_q, sel_count_d;

  logic             space;
  logic             accept;
  logic             win_found;
  logic [SW-1:0]    win_idx;
  logic [KW-1:0]    best_key;
  logic [NCH-1:0]   ack;
  int               idx;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign key_arr[gi] = bus.in_key[gi*KW +: KW];
      assign val_arr[gi] = bus.in_val[gi*VW +: VW];
    end
  endgenerate

  function automatic logic key_better(input logic [KW-1:0] a, input logic [KW-1:0] b);
`ifdef RA_PQ_KVSEL_MAX_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  // Scan in round-robin order from rr_ptr; a strict compare keeps the first tied channel.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best_key  = '0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (bus.in_valid[idx] && (!win_found || key_better(key_arr[idx], best_key))) begin
        win_found = 1'b1;
        win_idx   = SW'(idx);
        best_key  = key_arr[idx];
      end
    end
  end

  assign space  = ~out_valid_q | bus.out_ready;
  assign accept = space & (|bus.in_valid) & ~rst;

  always_comb begin
    ack = '0;
    if (accept) ack[win_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_key_d   = out_key_q;
    out_val_d   = out_val_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    sel_count_d = sel_count_q;
    if (out_valid_q && bus.out_ready) begin
      sel_count_d = sel_count_q + 1'b1;
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_key_d   = key_arr[win_idx];
      out_val_d   = val_arr[win_idx];
      out_src_d   = win_idx;
      // Explicit wrap so a non-power-of-two NCH never leaves the pointer out of range.
      rr_ptr_d    = (win_idx == SW'(NCH-1)) ? '0 : SW'(win_idx + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_key_q   <= '0;
      out_val_q   <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
      sel_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_key_q   <= out_key_d;
      out_val_q   <= out_val_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_count_q <= sel_count_d;
    end
  end

  assign bus.in_ack    = ack;
  assign bus.out_valid = out_valid_q;
  assign bus.out_key   = out_key_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_src   = out_src_q;
  assign sel_count     = sel_count_q;
endmodule
